// File: rtl/uart_boot_loader_pkg.sv
// uart_boot_loader shared types.
// Loader state encoding and default frame magic.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_WAIT = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  localparam logic [7:0] DEF_MAGIC = 8'hA5;

endpackage

// File: rtl/uart_boot_loader_strobe.sv
// byte_strobe: registered rising-edge detector.
// One pulse per rise of a level-style valid flag.
module byte_strobe (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lvl_i,
  output logic strb_o
);

  logic lvl_q;
  logic strb_q;

  // level starts "high" so a level already up at reset is not a new byte
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q  <= 1'b1;
      strb_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_i;
      strb_q <= lvl_i & ~lvl_q;
    end
  end

  assign strb_o = strb_q;

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses magic/len/data/chk frames from the UART
// and writes LE words to instruction memory, holding the CPU in reset.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter logic [7:0]  MAGIC       = DEF_MAGIC,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int IW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0]   MAXW  = 32'(MAX_WORDS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  logic          strb;
  state_e        state_q;
  logic [1:0]    bidx_q;
  logic [31:0]   n_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    sum_q;
  logic [23:0]   sh_q;
  logic [TW-1:0] tmr_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          cpu_rst_q;
  logic          done_q;
  logic          err_q;

  logic [31:0]   n_d;
  logic [31:0]   word_d;
  logic [IW-1:0] idx_d;
  logic          tmo;
  logic          go_err;
  logic          magic;

  byte_strobe u_strb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .lvl_i  (rx_ready_i),
    .strb_o (strb)
  );

  // next values of the length/word shifters and the failure decision
  always_comb begin
    n_d    = {rx_byte_i, n_q[31:8]};
    word_d = {rx_byte_i, sh_q};
    idx_d  = idx_q + 1'b1;
    tmo    = (tmr_q == TLAST);
    magic  = strb && (rx_byte_i == MAGIC);
    go_err = 1'b0;
    unique case (state_q)
      S_LEN:
        go_err = strb ? (bidx_q == 2'd3 && n_d > MAXW) : tmo;
      S_DATA:
        go_err = !strb && tmo;
      S_WAIT:
        go_err = strb;
      S_CHK:
        go_err = strb ? (rx_byte_i != sum_q) : tmo;
      default:
        go_err = 1'b0;
    endcase
  end

  // loader FSM with its datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      bidx_q    <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      sh_q      <= '0;
      tmr_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= BASE_ADDR;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (go_err) begin
      state_q   <= S_ERR;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (magic) begin
            state_q   <= S_LEN;
            bidx_q    <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            tmr_q     <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        S_LEN: begin
          if (strb) begin
            tmr_q  <= '0;
            n_q    <= n_d;
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              state_q <= (n_d == '0) ? S_CHK : S_DATA;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_DATA: begin
          if (strb) begin
            tmr_q  <= '0;
            sum_q  <= sum_q + rx_byte_i;
            sh_q   <= word_d[31:8];
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              we_q    <= 1'b1;
              wdata_q <= word_d;
              addr_q  <= BASE_ADDR + (32'(idx_q) << 2);
              state_q <= S_WAIT;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            we_q    <= 1'b0;
            idx_q   <= idx_d;
            state_q <= (32'(idx_d) == n_q) ? S_CHK : S_DATA;
          end
        end
        S_CHK: begin
          if (strb) begin
            state_q   <= S_DONE;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
